// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with iterative multiply/divide/modulo.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous, active-high reset
//   IN_VALID   operation presented this cycle
//   IN_READY   block can accept an operation (low while a multicycle op runs)
//   DATA_A     operand A
//   DATA_B     operand B / shift count (low SHAMT_W bits)
//   S_ALU      opcode
//   OUT_VALID  one-cycle pulse: ALU_OUT/FLAG_OUT updated this cycle
//   ALU_OUT    registered result
//   FLAG_OUT   registered {S,Z,C,V}
module alu_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DATA_A,
  input  logic [WIDTH-1:0] DATA_B,
  input  logic [3:0]       S_ALU,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [3:0]       FLAG_OUT
);

  localparam int CNT_W = SHAMT_W + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR  = 4'b0011,
    OP_XOR = 4'b0100, OP_MUL = 4'b0101, OP_DIV = 4'b0110, OP_MOD = 4'b0111,
    OP_SLL = 4'b1000, OP_ROL = 4'b1001, OP_SRL = 4'b1010, OP_SRA = 4'b1011,
    OP_NOP = 4'b1111
  } op_t;

  state_t             state, state_n;
  op_t                op, op_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   hi, hi_n, lo, lo_n, opnd, opnd_n;
  logic               out_valid_n;
  logic [WIDTH-1:0]   alu_out_n;
  logic [3:0]         flag_out_n;

  // Single-cycle datapath
  logic [WIDTH:0]     sc_sum;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c, sc_v, sc_multi, sc_nop;
  logic [SHAMT_W-1:0] sh, lidx, ridx;

  always_comb begin
    sh       = DATA_B[SHAMT_W-1:0];
    // Index of the last bit shifted out on left shifts / rotates (WIDTH-sh).
    lidx     = SHAMT_W'(WIDTH) - sh;
    ridx     = sh - SHAMT_W'(1);
    sc_sum   = '0;
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_multi = 1'b0;
    sc_nop   = 1'b0;
    case (op_t'(S_ALU))
      OP_ADD: begin
        sc_sum = {1'b0, DATA_A} + {1'b0, DATA_B};
        sc_res = sc_sum[WIDTH-1:0];
        sc_c   = sc_sum[WIDTH];
        sc_v   = (DATA_A[WIDTH-1] == DATA_B[WIDTH-1]) && (sc_res[WIDTH-1] != DATA_A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_sum = {1'b0, DATA_A} - {1'b0, DATA_B};
        sc_res = sc_sum[WIDTH-1:0];
        sc_c   = sc_sum[WIDTH];
        sc_v   = (DATA_A[WIDTH-1] != DATA_B[WIDTH-1]) && (sc_res[WIDTH-1] != DATA_A[WIDTH-1]);
      end
      OP_AND: sc_res = DATA_A & DATA_B;
      OP_OR:  sc_res = DATA_A | DATA_B;
      OP_XOR: sc_res = DATA_A ^ DATA_B;
      OP_SLL: begin
        sc_res = DATA_A << sh;
        sc_c   = (sh != '0) && DATA_A[lidx];
      end
      OP_ROL: begin
        sc_res = (DATA_A << sh) | (DATA_A >> (WIDTH - int'(sh)));
        sc_c   = (sh != '0) && DATA_A[lidx];
      end
      OP_SRL: begin
        sc_res = DATA_A >> sh;
        sc_c   = (sh != '0) && DATA_A[ridx];
      end
      OP_SRA: begin
        sc_res = $signed(DATA_A) >>> sh;
        sc_c   = (sh != '0) && DATA_A[ridx];
      end
      OP_MUL, OP_DIV, OP_MOD: sc_multi = 1'b1;
      default: sc_nop = 1'b1;
    endcase
  end

  // Iterative step. MUL keeps {hi,lo} as {partial product, remaining multiplier};
  // DIV/MOD keeps hi as the partial remainder and shifts quotient bits into lo.
  logic [WIDTH:0]   mul_sum, div_tmp;
  logic [WIDTH-1:0] div_diff, step_hi, step_lo;
  logic             div_ge;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_tmp  = {hi, lo[WIDTH-1]};
    div_ge   = div_tmp >= {1'b0, opnd};
    // When div_ge holds the true difference is below opnd, so WIDTH bits suffice.
    div_diff = div_tmp[WIDTH-1:0] - opnd;
    if (op == OP_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_diff : div_tmp[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], div_ge};
    end
  end

  // Next-state / output logic
  always_comb begin
    state_n     = state;
    op_n        = op;
    cnt_n       = cnt;
    hi_n        = hi;
    lo_n        = lo;
    opnd_n      = opnd;
    out_valid_n = 1'b0;
    alu_out_n   = ALU_OUT;
    flag_out_n  = FLAG_OUT;
    IN_READY    = (state == IDLE);
    case (state)
      IDLE: begin
        if (IN_VALID) begin
          if (sc_multi) begin
            state_n = BUSY;
            op_n    = op_t'(S_ALU);
            cnt_n   = CNT_W'(WIDTH);
            hi_n    = '0;
            lo_n    = DATA_A;
            opnd_n  = DATA_B;
          end else begin
            out_valid_n = 1'b1;
            if (sc_nop) begin
              alu_out_n = '0;
            end else begin
              alu_out_n  = sc_res;
              flag_out_n = {sc_res[WIDTH-1], sc_res == '0, sc_c, sc_v};
            end
          end
        end
      end
      BUSY: begin
        hi_n  = step_hi;
        lo_n  = step_lo;
        cnt_n = cnt - CNT_W'(1);
        // The last step is folded into the result register so the output
        // appears in the same cycle the counter would hit zero.
        if (cnt == CNT_W'(1)) begin
          state_n     = IDLE;
          out_valid_n = 1'b1;
          alu_out_n   = (op == OP_MOD) ? step_hi : step_lo;
          flag_out_n  = {alu_out_n[WIDTH-1], alu_out_n == '0,
                         (op == OP_MUL) && (step_hi != '0),
                         (op != OP_MUL) && (opnd == '0)};
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      op        <= OP_NOP;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      OUT_VALID <= 1'b0;
      ALU_OUT   <= '0;
      FLAG_OUT  <= '0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      cnt       <= cnt_n;
      hi        <= hi_n;
      lo        <= lo_n;
      opnd      <= opnd_n;
      OUT_VALID <= out_valid_n;
      ALU_OUT   <= alu_out_n;
      FLAG_OUT  <= flag_out_n;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] DATA_A, DATA_B;
  logic [3:0]   S_ALU;
  logic         OUT_VALID;
  logic [W-1:0] ALU_OUT;
  logic [3:0]   FLAG_OUT;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
  } exp_t;

  exp_t       sbq[$];
  int         tests = 0;
  int         fails = 0;
  logic [3:0] mflags = 4'b0000;

  alu_seq #(.WIDTH(W), .SHAMT_W(4)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DATA_A(DATA_A), .DATA_B(DATA_B), .S_ALU(S_ALU),
    .OUT_VALID(OUT_VALID), .ALU_OUT(ALU_OUT), .FLAG_OUT(FLAG_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {result, S, Z, C, V}; pf = flags to hold on NOP.
  function automatic logic [19:0] ref_op(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] pf);
    logic [31:0] p;
    logic [15:0] r;
    logic        c, v;
    int          sh, s;
    p  = '0; r = '0; c = 1'b0; v = 1'b0;
    sh = int'(b[3:0]);
    case (op)
      4'd0: begin
        r = a + b;
        c = (int'(a) + int'(b)) > 65535;
        s = int'($signed(a)) + int'($signed(b));
        v = (s > 32767) || (s < -32768);
      end
      4'd1: begin
        r = a - b;
        c = a < b;
        s = int'($signed(a)) - int'($signed(b));
        v = (s > 32767) || (s < -32768);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin
        p = {16'h0, a} * {16'h0, b};
        r = p[15:0];
        c = p[31:16] != 16'h0;
      end
      4'd6: if (b == 16'h0) begin r = 16'hFFFF; v = 1'b1; end else r = a / b;
      4'd7: if (b == 16'h0) begin r = a; v = 1'b1; end else r = a % b;
      4'd8: begin r = a << sh; c = (sh != 0) ? a[16-sh] : 1'b0; end
      4'd9: begin
        r = a;
        for (int i = 0; i < sh; i++) r = {r[14:0], r[15]};
        c = (sh != 0) ? r[0] : 1'b0;
      end
      4'd10: begin r = a >> sh; c = (sh != 0) ? a[sh-1] : 1'b0; end
      4'd11: begin r = 16'($signed(a) >>> sh); c = (sh != 0) ? a[sh-1] : 1'b0; end
      default: return {16'h0000, pf};
    endcase
    return {r, r[15], r == 16'h0, c, v};
  endfunction

  // Present an op, hold it until accepted, and queue its expected output.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [3:0] ef, input bit expect_out);
    int n = 0;
    IN_VALID = 1'b1; S_ALU = op; DATA_A = a; DATA_B = b;
    while (IN_READY !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("issue_ready_wait", {31'b0, IN_READY}, 32'd1);
    if (expect_out) begin
      sbq.push_back('{er, ef});
      mflags = ef;
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    DATA_A = W'($urandom); DATA_B = W'($urandom); S_ALU = 4'($urandom);
  endtask

  task automatic rissue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [19:0] e;
    e = ref_op(op, a, b, mflags);
    issue(op, a, b, e[19:4], e[3:0], 1'b1);
  endtask

  always @(negedge CLK) begin
    if (OUT_VALID === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_out_valid", {31'b0, OUT_VALID}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("alu_out", {16'h0, ALU_OUT}, {16'h0, e.res});
        chk("flag_out", {28'h0, FLAG_OUT}, {28'h0, e.flg});
      end
    end
  end

  initial begin
    logic [3:0] ops[13];
    logic [W-1:0] ra, rb;
    int n;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};
    RST = 1'b1; IN_VALID = 1'b0; DATA_A = '0; DATA_B = '0; S_ALU = 4'b1111;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("reset_in_ready", {31'b0, IN_READY}, 32'd1);
    chk("reset_out_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("reset_alu_out", {16'h0, ALU_OUT}, 32'd0);
    chk("reset_flag_out", {28'h0, FLAG_OUT}, 32'd0);

    issue(4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b1);
    chk("add_latency1", {31'b0, OUT_VALID}, 32'd1);
    @(negedge CLK);

    // Back-to-back single-cycle ops
    issue(4'b0001, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010, 1'b1);
    issue(4'b0010, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b1);
    chk("b2b_out_valid", {31'b0, OUT_VALID}, 32'd1);

    // Multicycle MUL: 16 busy cycles, result in the 17th
    issue(4'b0101, 16'h0100, 16'h0100, 16'h0000, 4'b0110, 1'b1);
    for (int k = 0; k < 16; k++) begin
      chk("mul_busy_ready", {31'b0, IN_READY}, 32'd0);
      chk("mul_busy_valid", {31'b0, OUT_VALID}, 32'd0);
      @(negedge CLK);
    end
    chk("mul_done_valid", {31'b0, OUT_VALID}, 32'd1);
    chk("mul_done_ready", {31'b0, IN_READY}, 32'd1);
    // Accepted in the OUT_VALID cycle of the previous MUL
    issue(4'b0101, 16'd7, 16'd6, 16'h002A, 4'b0000, 1'b1);

    // DIV/MOD; each is held while the block is busy
    issue(4'b0110, 16'd100, 16'd7, 16'h000E, 4'b0000, 1'b1);
    issue(4'b0111, 16'd100, 16'd7, 16'h0002, 4'b0000, 1'b1);
    issue(4'b0110, 16'd5, 16'd0, 16'hFFFF, 4'b1001, 1'b1);
    issue(4'b1111, 16'h1234, 16'h5678, 16'h0000, 4'b1001, 1'b1);
    issue(4'b0111, 16'd5, 16'd0, 16'h0005, 4'b0001, 1'b1);

    // Shifts
    issue(4'b1001, 16'h8001, 16'd1, 16'h0003, 4'b0010, 1'b1);
    issue(4'b1011, 16'h8001, 16'd1, 16'hC000, 4'b1010, 1'b1);
    issue(4'b1010, 16'h8001, 16'd0, 16'h8001, 4'b1000, 1'b1);
    issue(4'b1000, 16'h8001, 16'd15, 16'h8000, 4'b1000, 1'b1);
    issue(4'b1100, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 1'b1);

    // Random ops checked against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 16'h0 : W'($urandom);
      rissue(ops[$urandom_range(0, 12)], ra, rb);
    end

    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_1", sbq.size(), 32'd0);

    // Reset in BUSY cycle 5 of a DIV: abandoned, no output
    issue(4'b0110, 16'h1234, 16'd5, 16'h0000, 4'b0000, 1'b0);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    mflags = 4'b0000;
    chk("rst_busy_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("rst_busy_alu_out", {16'h0, ALU_OUT}, 32'd0);
    chk("rst_busy_flag_out", {28'h0, FLAG_OUT}, 32'd0);
    chk("rst_busy_ready", {31'b0, IN_READY}, 32'd1);
    repeat (20) @(negedge CLK);
    issue(4'b1111, 16'hAAAA, 16'h5555, 16'h0000, 4'b0000, 1'b1);
    chk("nop_pulse", {31'b0, OUT_VALID}, 32'd1);
    @(negedge CLK);
    chk("nop_single_pulse", {31'b0, OUT_VALID}, 32'd0);

    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_2", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
